// File: rtl/counter_sequencer.sv
// Run/pause/step sequencer for the 3-bit up/down counter: prescaled ticks, four count modes,
// and turnaround/completion markers predicted from the counter's feedback value.
module counter_sequencer #(
  parameter int PRESCALE_W = 24,
  parameter int COUNT_W    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  step,
  input  logic [1:0]            mode,
  input  logic [PRESCALE_W-1:0] period,
  input  logic [COUNT_W-1:0]    count_in,
  output logic                  cnt_enable,
  output logic                  cnt_dir,
  output logic                  cnt_clear,
  output logic                  busy,
  output logic [1:0]            state,
  output logic                  event_pulse
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    RUN    = 2'd2,
    PAUSED = 2'd3
  } state_t;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PING = 2'b10;
  localparam logic [1:0] MODE_ONCE = 2'b11;

  state_t                  state_q, state_d;
  logic [PRESCALE_W-1:0]   prescaler, prescaler_d;
  logic [PRESCALE_W-1:0]   period_q, period_d;
  logic [1:0]              mode_q, mode_d;
  logic                    dir_d, enable_d, clear_d, event_d;
  logic                    tick_d, tick_now, turn_now, done_now;
  logic [COUNT_W-1:0]      count_pred;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      prescaler   <= '0;
      period_q    <= '0;
      mode_q      <= 2'b00;
      cnt_dir     <= 1'b1;
      cnt_enable  <= 1'b0;
      cnt_clear   <= 1'b0;
      event_pulse <= 1'b0;
    end else begin
      state_q     <= state_d;
      prescaler   <= prescaler_d;
      period_q    <= period_d;
      mode_q      <= mode_d;
      cnt_dir     <= dir_d;
      cnt_enable  <= enable_d;
      cnt_clear   <= clear_d;
      event_pulse <= event_d;
    end
  end

  // Outputs are registered, so the event for the next tick is judged against the count the
  // counter will hold next cycle, reconstructed from the strobes we are driving right now.
  always_comb begin
    state_d     = state_q;
    prescaler_d = prescaler;
    period_d    = period_q;
    mode_d      = mode_q;
    dir_d       = cnt_dir;
    enable_d    = 1'b0;
    clear_d     = 1'b0;
    event_d     = 1'b0;
    tick_d      = 1'b0;
    count_pred  = count_in;

    tick_now = cnt_enable && !cnt_clear;
    turn_now = tick_now && event_pulse && (mode_q == MODE_PING);
    done_now = tick_now && event_pulse && (mode_q == MODE_ONCE);

    if (turn_now) begin
      dir_d = ~cnt_dir;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = CLEAR;
          mode_d      = mode;
          period_d    = period;
          dir_d       = (mode != MODE_DOWN);
          prescaler_d = '0;
          enable_d    = 1'b1;
          clear_d     = 1'b1;
        end
      end
      CLEAR, RUN: begin
        if (done_now) begin
          state_d = IDLE;
        end else if (stop && state_q == RUN) begin
          state_d = PAUSED;
        end else begin
          state_d = RUN;
          if (prescaler == period_q) begin
            tick_d      = 1'b1;
            prescaler_d = '0;
          end else begin
            prescaler_d = prescaler + {{(PRESCALE_W-1){1'b0}}, 1'b1};
          end
        end
      end
      PAUSED: begin
        if (done_now) begin
          state_d = IDLE;
        end else if (stop) begin
          state_d = IDLE;
        end else if (start) begin
          state_d     = RUN;
          period_d    = period;
          prescaler_d = '0;
        end else if (step) begin
          tick_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (cnt_clear) begin
      count_pred = '0;
    end else if (cnt_enable) begin
      count_pred = cnt_dir ? count_in + COUNT_W'(1) : count_in - COUNT_W'(1);
    end

    if (tick_d) begin
      enable_d = 1'b1;
      case (mode_d)
        MODE_UP:   event_d = (count_pred == COUNT_W'(7));
        MODE_DOWN: event_d = (count_pred == COUNT_W'(0));
        MODE_PING: event_d = dir_d ? (count_pred == COUNT_W'(6)) : (count_pred == COUNT_W'(1));
        MODE_ONCE: event_d = (count_pred == COUNT_W'(6));
        default:   event_d = 1'b0;
      endcase
    end
  end

  assign state = state_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer: a behavioural 3-bit counter closes the feedback loop and a
// queue of hand-derived per-cycle expectations is checked after every clock edge.
module tb_counter_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, stop, step;
  logic [1:0]  mode;
  logic [23:0] period;
  logic [2:0]  count = 3'd5;
  logic        cnt_enable, cnt_dir, cnt_clear, busy, event_pulse;
  logic [1:0]  state;

  int assertions = 0;
  int failures   = 0;

  logic [9:0] exp_q[$];
  string      tag_q[$];

  counter_sequencer #(.PRESCALE_W(24), .COUNT_W(3)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .step(step),
    .mode(mode), .period(period), .count_in(count),
    .cnt_enable(cnt_enable), .cnt_dir(cnt_dir), .cnt_clear(cnt_clear),
    .busy(busy), .state(state), .event_pulse(event_pulse)
  );

  always #5 clk = ~clk;

  // The counter being sequenced; it powers up at 5 so the clear strobe is visible.
  always_ff @(posedge clk) begin
    if (cnt_enable === 1'b1) begin
      if (cnt_clear) count <= 3'd0;
      else if (cnt_dir) count <= count + 3'd1;
      else count <= count - 3'd1;
    end
  end

  // {state, busy, enable, clear, dir, event, count}
  function automatic logic [9:0] mk(input logic [1:0] st, input logic en, input logic clr,
                                    input logic dir, input logic ev, input int cnt);
    logic [2:0] c;
    c = cnt[2:0];
    return {st, (st != 2'd0), en, clr, dir, ev, c};
  endfunction

  task automatic checkOutput();
    logic [9:0] expv;
    logic [9:0] obs;
    string      tag;
    expv = exp_q.pop_front();
    tag  = tag_q.pop_front();
    obs  = {state, busy, cnt_enable, cnt_clear, cnt_dir, event_pulse, count};
    assertions++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed st/bsy/en/clr/dir/ev/cnt=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic rst_n, input logic st, input logic sp, input logic stp,
                               input string tag, input logic [9:0] expv);
    reset = rst_n;
    start = st;
    stop  = sp;
    step  = stp;
    exp_q.push_back(expv);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0;
    mode = 2'b00; period = 24'd0;
    #2;

    // Reset
    applyStimulus(0, 0, 0, 0, "reset0", mk(0, 0, 0, 1, 0, 5));
    applyStimulus(0, 0, 0, 0, "reset1", mk(0, 0, 0, 1, 0, 5));

    // Mode up, tick every cycle, 7->0 wrap event
    $display("[TB] up mode, period 0");
    mode = 2'b00; period = 24'd0;
    applyStimulus(1, 1, 0, 0, "up_clear", mk(1, 1, 1, 1, 0, 5));
    for (int c = 0; c <= 7; c++)
      applyStimulus(1, 0, 0, 0, $sformatf("up_tick%0d", c), mk(2, 1, 0, 1, c == 7, c));
    applyStimulus(1, 0, 0, 0, "up_wrap", mk(2, 1, 0, 1, 0, 0));
    applyStimulus(1, 0, 1, 0, "up_pause", mk(3, 0, 0, 1, 0, 1));
    applyStimulus(1, 0, 1, 0, "up_idle", mk(0, 0, 0, 1, 0, 1));

    // Ping-pong
    $display("[TB] ping-pong mode");
    mode = 2'b10;
    applyStimulus(1, 1, 0, 0, "pp_clear", mk(1, 1, 1, 1, 0, 1));
    for (int c = 0; c <= 6; c++)
      applyStimulus(1, 0, 0, 0, $sformatf("pp_up%0d", c), mk(2, 1, 0, 1, c == 6, c));
    for (int c = 7; c >= 1; c--)
      applyStimulus(1, 0, 0, 0, $sformatf("pp_dn%0d", c), mk(2, 1, 0, 0, c == 1, c));
    applyStimulus(1, 0, 0, 0, "pp_turn0", mk(2, 1, 0, 1, 0, 0));
    applyStimulus(1, 0, 0, 0, "pp_turn1", mk(2, 1, 0, 1, 0, 1));
    applyStimulus(1, 0, 1, 0, "pp_pause", mk(3, 0, 0, 1, 0, 2));
    applyStimulus(1, 0, 1, 0, "pp_idle", mk(0, 0, 0, 1, 0, 2));

    // Prescaled run, pause, single steps, resume
    $display("[TB] period 3 with pause and step");
    mode = 2'b00; period = 24'd3;
    applyStimulus(1, 1, 0, 0, "ps_clear", mk(1, 1, 1, 1, 0, 2));
    for (int t = 0; t < 2; t++) begin
      for (int w = 0; w < 3; w++)
        applyStimulus(1, 0, 0, 0, $sformatf("ps_wait%0d_%0d", t, w), mk(2, 0, 0, 1, 0, t));
      applyStimulus(1, 0, 0, 0, $sformatf("ps_tick%0d", t), mk(2, 1, 0, 1, 0, t));
    end
    applyStimulus(1, 0, 1, 0, "ps_pause", mk(3, 0, 0, 1, 0, 2));
    applyStimulus(1, 0, 0, 0, "ps_hold0", mk(3, 0, 0, 1, 0, 2));
    applyStimulus(1, 0, 0, 0, "ps_hold1", mk(3, 0, 0, 1, 0, 2));
    applyStimulus(1, 0, 0, 1, "ps_step0", mk(3, 1, 0, 1, 0, 2));
    applyStimulus(1, 0, 0, 0, "ps_gap", mk(3, 0, 0, 1, 0, 3));
    applyStimulus(1, 0, 0, 1, "ps_step1", mk(3, 1, 0, 1, 0, 3));
    applyStimulus(1, 0, 0, 1, "ps_step2", mk(3, 1, 0, 1, 0, 4));
    applyStimulus(1, 0, 0, 0, "ps_after", mk(3, 0, 0, 1, 0, 5));
    applyStimulus(1, 1, 0, 0, "ps_resume", mk(2, 0, 0, 1, 0, 5));
    period = 24'd0;
    for (int w = 0; w < 3; w++)
      applyStimulus(1, 0, 0, 0, $sformatf("ps_rwait%0d", w), mk(2, 0, 0, 1, 0, 5));
    applyStimulus(1, 0, 0, 0, "ps_rtick", mk(2, 1, 0, 1, 0, 5));

    // Start and stop together in RUN: stop wins; then step ignored in IDLE
    applyStimulus(1, 1, 1, 0, "prio_pause", mk(3, 0, 0, 1, 0, 6));
    applyStimulus(1, 0, 1, 0, "prio_idle", mk(0, 0, 0, 1, 0, 6));
    applyStimulus(1, 0, 0, 1, "idle_step", mk(0, 0, 0, 1, 0, 6));
    applyStimulus(1, 0, 0, 0, "idle_quiet", mk(0, 0, 0, 1, 0, 6));

    // One-shot, period 1
    $display("[TB] one-shot mode, period 1");
    mode = 2'b11; period = 24'd1;
    applyStimulus(1, 1, 0, 0, "os_clear", mk(1, 1, 1, 1, 0, 6));
    for (int c = 0; c <= 6; c++) begin
      applyStimulus(1, 0, 0, 0, $sformatf("os_wait%0d", c), mk(2, 0, 0, 1, 0, c));
      applyStimulus(1, 0, 0, 0, $sformatf("os_tick%0d", c), mk(2, 1, 0, 1, c == 6, c));
    end
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 0, 0, 0, $sformatf("os_done%0d", i), mk(0, 0, 0, 1, 0, 7));

    // Down mode, then reset while ticks are due
    $display("[TB] down mode with reset mid-run");
    mode = 2'b01; period = 24'd0;
    applyStimulus(1, 1, 0, 0, "dn_clear", mk(1, 1, 1, 0, 0, 7));
    applyStimulus(1, 0, 0, 0, "dn_tick0", mk(2, 1, 0, 0, 1, 0));
    applyStimulus(1, 0, 0, 0, "dn_tick7", mk(2, 1, 0, 0, 0, 7));
    applyStimulus(1, 0, 0, 0, "dn_tick6", mk(2, 1, 0, 0, 0, 6));
    applyStimulus(0, 0, 0, 0, "rst_run0", mk(0, 0, 0, 1, 0, 5));
    applyStimulus(0, 0, 0, 0, "rst_run1", mk(0, 0, 0, 1, 0, 5));
    applyStimulus(1, 0, 0, 0, "rst_rel", mk(0, 0, 0, 1, 0, 5));

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
